id_ex_stage: RTL

ID/EX pipeline register for the RV32 core, placed directly upstream of the combinational `alu`. It captures decoded instructions from decode and the register file, resolves RAW hazards by forwarding from EX/MEM/WB or by stalling, selects the final ALU operands, and presents `funct7`, `alu_op`, `operand_a` and `operand_b` to the ALU. It also carries the destination/control fields forward to MEM, using a valid/ready handshake on both sides.

---
 rtl/rv32_pkg.sv | 45 ++++
 rtl/id_ex_hazard_fwd.sv | 95 +++++++++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared types and constants for the RV32 core pipeline.
//   XLEN      : datapath width
//   REG_AW    : register index width
//   alu_op_e  : 3-bit ALU function select
//   id_ex_t   : fields registered by the ID/EX stage
//   producer_hit : true when a valid, writing producer targets a given index
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        alu_op_e           alu_op;
        logic              funct7;
        logic [XLEN-1:0]   operand_a;
        logic [XLEN-1:0]   operand_b;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_we;
        logic              is_load;
    } id_ex_t;

    function automatic logic producer_hit(input logic              valid,
                                          input logic              reg_we,
                                          input logic [REG_AW-1:0] rd,
                                          input logic [REG_AW-1:0] rs);
        return valid && reg_we && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_hazard_fwd.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_fwd
// Combinational operand resolution and hazard detection for the ID/EX stage.
// Configuration macro: FORWARDING_EN
//   defined   : forward from EX > MEM > WB, stall only on load-use
//   undefined : no forwarding, stall on any used nonzero source that matches
//               a valid writing producer in EX, MEM or WB
// Ports:
//   id_rs1/2, id_rs1/2_used, id_rs1/2_data : decoded sources and RF read data
//   ex_valid/ex_reg_we/ex_is_load/ex_rd     : instruction held in the stage
//   ex_result                               : ALU result of the held instruction
//   mem_*/wb_*                              : downstream producers
//   fwd_rs1/2                               : resolved source values
//   hazard                                  : capture must be refused this cycle
// -----------------------------------------------------------------------------
module id_ex_hazard_fwd
    import rv32_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              ex_valid,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic              wb_reg_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_rs1,
    output logic [XLEN-1:0]   fwd_rs2,
    output logic              hazard
);

    // Match vectors ordered {wb, mem, ex}; bit 0 has the highest priority.
    logic [2:0] hit1;
    logic [2:0] hit2;

    assign hit1 = {producer_hit(wb_valid,  wb_reg_we,  wb_rd,  id_rs1),
                   producer_hit(mem_valid, mem_reg_we, mem_rd, id_rs1),
                   producer_hit(ex_valid,  ex_reg_we,  ex_rd,  id_rs1)};
    assign hit2 = {producer_hit(wb_valid,  wb_reg_we,  wb_rd,  id_rs2),
                   producer_hit(mem_valid, mem_reg_we, mem_rd, id_rs2),
                   producer_hit(ex_valid,  ex_reg_we,  ex_rd,  id_rs2)};

`ifdef FORWARDING_EN

    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves it unassigned, which would otherwise infer a latch.
        fwd_rs1 = id_rs1_data;
        fwd_rs2 = id_rs2_data;

        if (id_rs1 == '0)  fwd_rs1 = '0;
        else if (hit1[0])  fwd_rs1 = ex_result;
        else if (hit1[1])  fwd_rs1 = mem_data;
        else if (hit1[2])  fwd_rs1 = wb_data;

        if (id_rs2 == '0)  fwd_rs2 = '0;
        else if (hit2[0])  fwd_rs2 = ex_result;
        else if (hit2[1])  fwd_rs2 = mem_data;
        else if (hit2[2])  fwd_rs2 = wb_data;
    end

    // A load's value only exists once it reaches MEM, so the consumer waits
    // one cycle and then picks it up from mem_data.
    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

`else

    assign fwd_rs1 = (id_rs1 == '0) ? '0 : id_rs1_data;
    assign fwd_rs2 = (id_rs2 == '0) ? '0 : id_rs2_data;

    // The register file is not write-through, so a pending WB write blocks
    // the read just like EX and MEM do.
    assign hazard = (id_rs1_used && (id_rs1 != '0) && (|hit1)) ||
                    (id_rs2_used && (id_rs2 != '0) && (|hit2));

    // Producer data and load flag only matter when forwarding is built in.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_result, mem_data, wb_data, ex_is_load};

`endif

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register feeding the combinational ALU. Holds one
// instruction, resolves RAW hazards (forward or stall) and registers the final
// ALU operands plus the control fields carried on to MEM.
// Configuration macro: FORWARDING_EN (see id_ex_hazard_fwd).
// Ports:
//   clk, rst_n (synchronous, active low), flush (drop held instruction)
//   id_valid/id_ready + id_* : decode-side handshake and instruction fields
//   ex_result                : ALU output for the held instruction
//   mem_*, wb_*              : downstream producers for forwarding/hazards
//   ex_valid/ex_ready + ex_* : registered outputs to the ALU and MEM
// -----------------------------------------------------------------------------
module id_ex_stage
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_pc,
    input  logic              id_use_imm,
    input  logic [2:0]        id_alu_op,
    input  logic              id_funct7,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic              wb_reg_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [2:0]        ex_alu_op,
    output logic              ex_funct7,
    output logic [XLEN-1:0]   ex_operand_a,
    output logic [XLEN-1:0]   ex_operand_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic              ex_is_load
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;
    logic            slot_free;

    id_ex_hazard_fwd u_hazard_fwd (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .ex_valid    (ex_valid),
        .ex_reg_we   (ex_q.reg_we),
        .ex_is_load  (ex_q.is_load),
        .ex_rd       (ex_q.rd),
        .ex_result   (ex_result),
        .mem_valid   (mem_valid),
        .mem_reg_we  (mem_reg_we),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .wb_valid    (wb_valid),
        .wb_reg_we   (wb_reg_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2),
        .hazard      (hazard)
    );

    // The slot can take a new instruction when empty or draining this cycle.
    assign slot_free = !ex_valid || ex_ready;
    assign id_ready  = slot_free && !hazard && !flush;

    always_comb begin
        ex_d.pc         = id_pc;
        ex_d.alu_op     = alu_op_e'(id_alu_op);
        ex_d.funct7     = id_funct7;
        ex_d.operand_a  = id_use_pc  ? id_pc  : fwd_rs1;
        ex_d.operand_b  = id_use_imm ? id_imm : fwd_rs2;
        ex_d.store_data = fwd_rs2;
        ex_d.rd         = id_rd;
        ex_d.reg_we     = id_reg_we;
        ex_d.is_load    = id_is_load;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement or process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (id_valid && id_ready) begin
            ex_valid <= 1'b1;
            ex_q     <= ex_d;
        end else if (ex_valid && ex_ready) begin
            // Drained with nothing to replace it: bubble, fields hold.
            ex_valid <= 1'b0;
        end
    end

    assign ex_pc         = ex_q.pc;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct7     = ex_q.funct7;
    assign ex_operand_a  = ex_q.operand_a;
    assign ex_operand_b  = ex_q.operand_b;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_we     = ex_q.reg_we;
    assign ex_is_load    = ex_q.is_load;

endmodule
